// File: rtl/seq_detector_param_if.sv
// Serial-bit detector bus: stimulus, pattern load and counter clear in,
// match flags and counter state out.
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             clear_cnt;
  logic             y;
  logic             y_q;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output in_valid, in, pat_load, pat_in, clear_cnt,
    input  y, y_q, match_cnt, cnt_sat
  );

  modport slave (
    input  in_valid, in, pat_load, pat_in, clear_cnt,
    output y, y_q, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised Mealy bit-pattern detector with a runtime-loadable pattern,
// optional overlap, registered match flag and saturating match counter.
//
//   state s_q | meaning
//   0         | no pattern prefix matched yet
//   k         | the last k accepted bits equal the first k pattern bits
//   PAT_W-1   | one bit away from a match
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1101),
  parameter bit               OVERLAP = 1'b0,
  parameter int               CNT_W   = 8
) (
  input logic                clk,
  input logic                rst,
  seq_detector_param_if.slave bus
);

  localparam int             SW     = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [SW-1:0]  S_LAST = SW'(PAT_W - 1);
  localparam logic [PAT_W:0] ONES   = '1;

  logic [SW-1:0]    s_q, s_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [PAT_W-1:0] pre;
  logic [PAT_W:0]   w;
  logic [SW-1:0]    nxt;
  logic [SW-1:0]    ovl;
  logic             s_ok;
  logic             hit;
  logic             y_c;

  generate
    if ((1 << SW) > PAT_W) begin : g_range
      assign s_ok = (s_q <= S_LAST);
    end else begin : g_full
      assign s_ok = 1'b1;
    end
  endgenerate

  // w is the matched prefix followed by the incoming bit; the next state is
  // the longest suffix of w that is also a pattern prefix (KMP fallback).
  always_comb begin
    pre = pat_q >> (PAT_W - int'(s_q));
    w   = {pre, bus.in};
    nxt = '0;
    for (int k = 1; k < PAT_W; k++) begin
      if ((k <= int'(s_q) + 1) &&
          ((w & (ONES >> (PAT_W + 1 - k))) == ({1'b0, pat_q} >> (PAT_W - k))))
        nxt = SW'(k);
    end
    ovl = '0;
    for (int k = 1; k < PAT_W; k++) begin
      if (({1'b0, pat_q} & (ONES >> (PAT_W + 1 - k))) == ({1'b0, pat_q} >> (PAT_W - k)))
        ovl = SW'(k);
    end
  end

  always_comb begin
    s_d   = s_q;
    pat_d = pat_q;
    cnt_d = cnt_q;
    hit   = (s_q == S_LAST) && (bus.in == pat_q[0]);
    y_c   = bus.in_valid & ~bus.pat_load & ~rst & hit;
    y_d   = y_c;

    if (bus.pat_load) begin
      pat_d = bus.pat_in;
      s_d   = '0;
    end else if (!s_ok) begin
      s_d = '0;
    end else if (bus.in_valid) begin
      if (hit) s_d = OVERLAP ? ovl : '0;
      else     s_d = nxt;
    end

    // clear beats a coincident match
    if (bus.clear_cnt)       cnt_d = '0;
    else if (y_c && !sat_q)  cnt_d = cnt_q + CNT_W'(1);
    sat_d = &cnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      pat_q <= PATTERN;
      y_q   <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      pat_q <= pat_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign bus.y         = y_c;
  assign bus.y_q       = y_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three instances (non-overlap, overlap, 2-bit
// counter) driven in lockstep and compared against a bit-history model.
module tb_seq_detector_param;
  localparam int PAT_W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0, s_in = 1'b0, s_load = 1'b0, s_clr = 1'b0;
  logic [3:0] s_pat = 4'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(8)) if0 ();
  seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(8)) if1 ();
  seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(2)) if2 ();

  assign if0.in_valid = s_valid; assign if0.in = s_in; assign if0.pat_load = s_load;
  assign if0.pat_in = s_pat;     assign if0.clear_cnt = s_clr;
  assign if1.in_valid = s_valid; assign if1.in = s_in; assign if1.pat_load = s_load;
  assign if1.pat_in = s_pat;     assign if1.clear_cnt = s_clr;
  assign if2.in_valid = s_valid; assign if2.in = s_in; assign if2.pat_load = s_load;
  assign if2.pat_in = s_pat;     assign if2.clear_cnt = s_clr;

  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(2))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Model: recent accepted bits (only the last PAT_W-1 matter) per mode.
  bit         hist_n[$];
  bit         hist_o[$];
  logic [3:0] m_pat = 4'b1101;
  bit         m_yq_n = 1'b0, m_yq_o = 1'b0;
  int         m_cnt0 = 0, m_cnt1 = 0, m_cnt2 = 0;

  function automatic bit ends_with_pat(input bit h[$], input logic [3:0] p, input bit b);
    if (h.size() < PAT_W - 1) return 1'b0;
    for (int i = 0; i < PAT_W - 1; i++)
      if (h[h.size() - (PAT_W - 1) + i] != p[PAT_W - 1 - i]) return 1'b0;
    return b == p[0];
  endfunction

  function automatic bit exp_y(input bit h[$]);
    return s_valid && !s_load && !rst && ends_with_pat(h, m_pat, s_in);
  endfunction

  function automatic int sat_inc(input int c, input bit inc, input bit clr, input int top);
    if (clr) return 0;
    if (inc && c < top) return c + 1;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit en, eo;
    en = exp_y(hist_n);
    eo = exp_y(hist_o);
    if (rst) begin
      hist_n.delete(); hist_o.delete();
      m_pat = 4'b1101; m_yq_n = 1'b0; m_yq_o = 1'b0;
      m_cnt0 = 0; m_cnt1 = 0; m_cnt2 = 0;
    end else begin
      m_yq_n = en; m_yq_o = eo;
      m_cnt0 = sat_inc(m_cnt0, en, s_clr, 255);
      m_cnt1 = sat_inc(m_cnt1, eo, s_clr, 255);
      m_cnt2 = sat_inc(m_cnt2, en, s_clr, 3);
      if (s_load) begin
        m_pat = s_pat;
        hist_n.delete(); hist_o.delete();
      end else if (s_valid) begin
        if (en) hist_n.delete();
        else begin
          hist_n.push_back(s_in);
          if (hist_n.size() > PAT_W - 1) void'(hist_n.pop_front());
        end
        hist_o.push_back(s_in);
        if (hist_o.size() > PAT_W - 1) void'(hist_o.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    bit en, eo;
    en = exp_y(hist_n);
    eo = exp_y(hist_o);
    chk("y0", if0.y, en);   chk("y1", if1.y, eo);   chk("y2", if2.y, en);
    chk("yq0", if0.y_q, m_yq_n); chk("yq1", if1.y_q, m_yq_o); chk("yq2", if2.y_q, m_yq_n);
    chk("cnt0", if0.match_cnt, m_cnt0); chk("cnt1", if1.match_cnt, m_cnt1);
    chk("cnt2", if2.match_cnt, m_cnt2);
    chk("sat0", if0.cnt_sat, m_cnt0 == 255); chk("sat1", if1.cnt_sat, m_cnt1 == 255);
    chk("sat2", if2.cnt_sat, m_cnt2 == 3);
  end

  // ly0 applies to the two non-overlap instances, ly1 to the overlap one; -1 skips.
  task automatic drive(input bit r, pl, cc, v, b, input logic [3:0] pi, input int ly0, ly1);
    rst = r; s_load = pl; s_clr = cc; s_valid = v; s_in = b; s_pat = pi;
    @(negedge clk);
    if (ly0 >= 0) begin
      chk("lit_y0", if0.y, ly0[0]);
      chk("lit_y2", if2.y, ly0[0]);
    end
    if (ly1 >= 0) chk("lit_y1", if1.y, ly1[0]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0, 0, 0);
  endtask

  task automatic idle(input bit b);
    drive(1'b0, 1'b0, 1'b0, 1'b0, b, 4'b0, 0, 0);
  endtask

  // Sends n bits MSB first; m0/m1 mark the bits expected to match.
  task automatic send(input logic [15:0] bits, input int n, input logic [15:0] m0,
                      input logic [15:0] m1);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 1'b0, 1'b1, bits[n-1-i], 4'b0, int'(m0[n-1-i]), int'(m1[n-1-i]));
  endtask

  initial begin
    do_reset();
    chk("rst_yq0", if0.y_q, 1'b0);
    chk("rst_cnt0", if0.match_cnt, 8'd0);

    // overlap vs non-overlap on 1101101
    send(16'b1101, 4, 16'b0001, 16'b0001);
    chk("t1_yq0", if0.y_q, 1'b1);
    send(16'b101, 3, 16'b000, 16'b001);
    chk("t2_yq1", if1.y_q, 1'b1);
    chk("t1_yq0_low", if0.y_q, 1'b0);
    idle(1'b0);
    chk("t1_cnt0", if0.match_cnt, 8'd1);
    chk("t2_cnt1", if1.match_cnt, 8'd2);

    // repeated ones keep the state parked at "11"
    do_reset();
    send(16'b111101, 6, 16'b000001, 16'b000001);
    send(16'b01101, 5, 16'b00001, 16'b00001);
    chk("t3_cnt0", if0.match_cnt, 8'd2);

    // invalid cycles are ignored
    do_reset();
    send(16'b1, 1, 16'b0, 16'b0); idle(1'b1);
    send(16'b1, 1, 16'b0, 16'b0); idle(1'b0);
    send(16'b0, 1, 16'b0, 16'b0); idle(1'b1); idle(1'b0);
    send(16'b1, 1, 16'b1, 16'b1);
    chk("t4_cnt0", if0.match_cnt, 8'd1);

    // runtime pattern load discards the bit presented with it
    do_reset();
    send(16'b110, 3, 16'b0, 16'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 0, 0);
    send(16'b1101, 4, 16'b0, 16'b0);
    send(16'b0110, 4, 16'b0001, 16'b0001);
    chk("t5_cnt0", if0.match_cnt, 8'd1);

    // 2-bit counter saturation and clear-beats-match
    do_reset();
    repeat (4) send(16'b1101, 4, 16'b0001, 16'b0001);
    chk("t6_cnt2_sat", if2.match_cnt, 2'd3);
    chk("t6_sat2", if2.cnt_sat, 1'b1);
    send(16'b1101, 4, 16'b0001, 16'b0001);
    chk("t6_cnt2_hold", if2.match_cnt, 2'd3);
    chk("t6_cnt0", if0.match_cnt, 8'd5);
    send(16'b110, 3, 16'b0, 16'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0, 1, 1);
    chk("t6_cnt2_clr", if2.match_cnt, 2'd0);
    chk("t6_sat2_clr", if2.cnt_sat, 1'b0);
    chk("t6_yq2_clr", if2.y_q, 1'b1);

    // reset mid-pattern
    do_reset();
    send(16'b110, 3, 16'b0, 16'b0);
    do_reset();
    chk("t7_yq0", if0.y_q, 1'b0);
    chk("t7_cnt0", if0.match_cnt, 8'd0);
    send(16'b1, 1, 16'b0, 16'b0);
    send(16'b1101, 4, 16'b0001, 16'b0001);
    chk("t7_cnt0_after", if0.match_cnt, 8'd1);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector: generalises the fixed 4-bit Mealy detector to any pattern width.
- Adds a runtime-loadable pattern, overlapping or non-overlapping mode, input qualification, a registered match output and a saturating match counter.
- Sits on a serial bit stream next to the existing FSM blocks.
- Consumers may use the combinational Mealy flag or the registered copy.

Parameters:
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101: pattern loaded at reset, PAT_W bits wide. The MSB is the first bit received.
- OVERLAP, 0: 0 = non-overlapping (history discarded after a match); 1 = overlapping (matched bits reused).
- CNT_W, 8: width of the match counter; must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  when high, `in` carries a bit to consume this cycle.
- in  input  1  serial data bit.
- pat_load  input  1  load `pat_in` into the pattern register.
- pat_in  input  PAT_W  new pattern, MSB first.
- clear_cnt  input  1  clear the match counter.
- y  output  1  Mealy match flag (combinational).
- y_q  output  1  y registered; one cycle later.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- Reset is synchronous, active-high, and sampled on rising clk. rst overrides every other input. On reset:
  - match state = 0
  - pattern register = PATTERN
  - y_q = 0
  - match_cnt = 0
  - cnt_sat = 0
  - y = 0 in the cycle after reset.
- Match state S ranges 0..PAT_W-1. S is the length of the longest suffix of the accepted bits that is a proper prefix of the pattern.
  - Accepted bits are those since the last reset, pat_load or match. In overlap mode, a match does not reset the history.
  - Implement as a prefix-length FSM; a history shift register compared against the pattern is also acceptable. Observable behaviour must be identical.
- Per accepted bit (in_valid=1, pat_load=0):
  - If `in` equals the pattern bit at position S (counting from the MSB) and S+1 = PAT_W, this is a match.
  - Otherwise the next S is the longest suffix of (matched prefix followed by `in`) that is also a prefix of the pattern.
- After a match:
  - OVERLAP=0: next S = 0.
  - OVERLAP=1: next S = longest proper suffix of the pattern that is also a prefix of the pattern.
- y = in_valid & ~pat_load & ~rst & (S = PAT_W-1) & (in = last pattern bit).
  - Purely combinational; zero latency.
  - Never asserted on an invalid cycle.
- y_q <= y each cycle; it reads 0 in the cycle after rst.
- in_valid=0: S holds and `in` is ignored.
- pat_load=1: the pattern register takes pat_in and S resets to 0. Any bit presented in that cycle is discarded. The new pattern applies from the next cycle.
- Counter:
  - Increments on each cycle where y=1.
  - Holds at 2^CNT_W-1; never wraps.
  - cnt_sat = (match_cnt == all-ones), registered with the count.
  - If clear_cnt and y are both high in the same cycle, clear wins: match_cnt = 0 and that match is not counted.
  - The clear does not affect S, y or y_q.
- Priority: rst > pat_load > in_valid. clear_cnt is independent of pat_load.
- No internal state may be uninitialised. All case statements are fully specified, and unreachable encodings go to S = 0.

Test Plan:
1. Defaults, OVERLAP=0, valid bits 1,1,0,1,1,0,1 -> y=1 on bit 4 only; y_q=1 one cycle later; match_cnt=1.
2. Same stream with OVERLAP=1 -> y=1 on bits 4 and 7; match_cnt=2.
3. Defaults, bits 1,1,1,1,0,1 -> a single match on bit 6, which checks that S holds at 2 through repeated 1s. Then bits 0,1,1,0,1 -> a match on the last bit.
4. Valid bits 1,1,0,1 with in_valid=0 cycles (in=1 and in=0) interleaved between them -> y stays 0 on every invalid cycle and pulses on the final valid bit only; match_cnt=1.
5. Send 1,1,0, then pat_load with pat_in=4'b0110 while in_valid=1 -> that bit is discarded and y=0. Then 1,1,0,1 -> no match. Then 0,1,1,0 -> y on the last bit.
6. CNT_W=2, four matches -> match_cnt=3, cnt_sat=1. A fifth match -> stays at 3. clear_cnt together with a match -> match_cnt=0, cnt_sat=0.
7. Send 1,1,0, then assert rst for one cycle, then send 1 -> no match; y_q=0 and match_cnt=0 after reset. Then 1,1,0,1 -> one match.
